// File: rtl/timer_ctrl.sv
// timer_ctrl: prescaled up-counter with one-shot / auto-reload modes.
// Launch parameters are latched into shadow registers so the running
// timer is immune to changes on load_val, prescale and periodic.
module timer_ctrl #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clock,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PS_W-1:0]  prescale,
    input  logic             periodic,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             irq,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        DONE    = 2'b10,
        ILLEGAL = 2'b11
    } stateT;

    stateT            r_state;
    stateT            w_nextState;

    logic [WIDTH-1:0] r_count;
    logic [PS_W-1:0]  r_ps;
    logic [WIDTH-1:0] r_shLoad;
    logic [PS_W-1:0]  r_shPrescale;
    logic             r_shPeriodic;
    logic             r_done;
    logic             r_irq;

    logic             w_running;
    logic             w_launch;
    logic             w_tick;
    logic             w_terminal;

    // Stop always beats a terminal tick, so a terminal event only counts
    // when the timer is running and not being aborted in the same cycle.
    assign w_running  = (r_state == RUN);
    assign w_launch   = ((r_state == IDLE) || (r_state == DONE)) && start && !stop;
    assign w_tick     = w_running && !stop && (r_ps == r_shPrescale);
    assign w_terminal = w_tick && (r_count == r_shLoad);

    // State register.
    always_ff @(posedge clock) begin
        if (res) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; the unused 11 encoding falls back to IDLE.
    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE: begin
                w_nextState = w_launch ? RUN : IDLE;
            end
            RUN: begin
                if (stop) begin
                    w_nextState = IDLE;
                end else if (w_terminal && !r_shPeriodic) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = RUN;
                end
            end
            DONE: begin
                if (w_launch) begin
                    w_nextState = RUN;
                end else if (stop || irq_clr) begin
                    w_nextState = IDLE;
                end else begin
                    w_nextState = DONE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Counter, prescaler, shadow copies, done pulse and sticky irq.
    always_ff @(posedge clock) begin
        if (res) begin
            r_count      <= '0;
            r_ps         <= '0;
            r_shLoad     <= '0;
            r_shPrescale <= '0;
            r_shPeriodic <= 1'b0;
            r_done       <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_launch) begin
                r_shLoad     <= load_val;
                r_shPrescale <= prescale;
                r_shPeriodic <= periodic;
                r_count      <= '0;
                r_ps         <= '0;
            end else if (w_running && !stop) begin
                if (w_tick) begin
                    r_ps <= '0;
                    if (w_terminal) begin
                        r_count <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end else begin
                    r_ps <= r_ps + PS_W'(1);
                end
            end
            if (w_terminal) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    // Output decode straight from registered state.
    always_comb begin
        busy  = (r_state == RUN);
        state = r_state;
        count = r_count;
        done  = r_done;
        irq   = r_irq;
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed scenarios followed by random traffic, every cycle
// compared against an arithmetic model of the timer (elapsed-cycle based).
module tb_timer_ctrl;

    logic       clock = 1'b0;
    logic       res;
    logic       start;
    logic       stop;
    logic [7:0] loadVal;
    logic [3:0] prescale;
    logic       periodic;
    logic       irqClr;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic       irq;
    logic [1:0] state;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model: 0 = IDLE, 1 = RUN, 2 = DONE.
    int mState   = 0;
    int mElapsed = 0;
    int mL       = 0;
    int mP       = 0;
    int mPer     = 0;
    int mCount   = 0;
    int mDone    = 0;
    int mIrq     = 0;

    timer_ctrl #(.WIDTH(8), .PS_W(4)) dut (
        .clock    (clock),
        .res      (res),
        .start    (start),
        .stop     (stop),
        .load_val (loadVal),
        .prescale (prescale),
        .periodic (periodic),
        .irq_clr  (irqClr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .irq      (irq),
        .state    (state)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic r, input logic s, input logic p, input logic c);
        res    = r;
        start  = s;
        stop   = p;
        irqClr = c;
    endtask

    // Count value follows from ticks elapsed since launch; terminal events
    // fall on every multiple of the full period (L+1)*(P+1).
    task automatic updateModel();
        int period;
        if (res) begin
            mState = 0; mElapsed = 0; mL = 0; mP = 0; mPer = 0;
            mCount = 0; mDone = 0; mIrq = 0;
        end else begin
            mDone = 0;
            if (mState == 1) begin
                if (stop) begin
                    mState = 0;
                    if (irqClr) mIrq = 0;
                end else begin
                    mElapsed++;
                    period = (mL + 1) * (mP + 1);
                    mCount = (mElapsed / (mP + 1)) % (mL + 1);
                    if (mElapsed % period == 0) begin
                        mDone = 1;
                        mIrq  = 1;
                        if (mPer == 0) mState = 2;
                    end else if (irqClr) begin
                        mIrq = 0;
                    end
                end
            end else begin
                if (irqClr) mIrq = 0;
                if (start && !stop) begin
                    mState = 1; mElapsed = 0; mCount = 0;
                    mL = int'(loadVal); mP = int'(prescale); mPer = int'(periodic);
                end else if (mState == 2 && (stop || irqClr)) begin
                    mState = 0;
                end
            end
        end
    endtask

    task automatic checkOne(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    endtask

    task automatic checkOutput();
        checkOne("count", 32'(count), 32'(mCount));
        checkOne("state", 32'(state), 32'(mState));
        checkOne("busy",  32'(busy),  32'(mState == 1));
        checkOne("done",  32'(done),  32'(mDone));
        checkOne("irq",   32'(irq),   32'(mIrq));
    endtask

    task automatic stepCycle();
        @(posedge clock);
        updateModel();
        #1;
        checkOutput();
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic runUntil(input int target, input int maxCycles);
        int n = 0;
        while (mCount != target && n < maxCycles) begin
            stepCycle();
            n++;
        end
        checkOne("reach", 32'(count), 32'(target));
    endtask

    task automatic launch(input logic [7:0] l, input logic [3:0] p, input logic per);
        loadVal  = l;
        prescale = p;
        periodic = per;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        loadVal = '0; prescale = '0; periodic = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepN(2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // One-shot, L=3, P=0.
        launch(8'd3, 4'd0, 1'b0);
        stepN(6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(2);

        // Periodic, L=1, P=2, inputs disturbed mid-run.
        launch(8'd1, 4'd2, 1'b1);
        stepN(14);
        loadVal = 8'd5; prescale = 4'd0; periodic = 1'b0;
        stepN(3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(8);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Abort at count 5 with L=9.
        launch(8'd9, 4'd0, 1'b0);
        runUntil(5, 20);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(3);

        // Stop coinciding with a terminal tick.
        launch(8'd2, 4'd0, 1'b0);
        runUntil(2, 10);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(2);

        // irq_clr coinciding with a terminal tick.
        launch(8'd2, 4'd0, 1'b1);
        runUntil(2, 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();

        // Reset mid-run at count 7, then relaunch with a redundant start.
        launch(8'd20, 4'd1, 1'b0);
        runUntil(7, 40);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        launch(8'd3, 4'd0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        stepN(5);

        // Full-range load value, load_val changed during the run.
        launch(8'hFF, 4'd0, 1'b0);
        loadVal = 8'd4;
        stepN(258);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                          ($urandom_range(15) == 0), ($urandom_range(7) == 0));
            loadVal  = ($urandom_range(15) == 0) ? 8'($urandom) : 8'($urandom_range(7));
            prescale = 4'($urandom_range(3));
            periodic = 1'($urandom_range(1));
            stepCycle();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and res.
REQ-002 Parameter: WIDTH, 8, bit width of count and load_val.
REQ-003 Parameter: PS_W, 4, bit width of prescale.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: res  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  launch request, level sampled per cycle.
REQ-007 Port: stop  input  1  abort request, level sampled per cycle.
REQ-008 Port: load_val  input  WIDTH  terminal count value.
REQ-009 Port: prescale  input  PS_W  clock divide ratio minus 1.
REQ-010 Port: periodic  input  1  1 = auto-reload mode, 0 = one-shot mode.
REQ-011 Port: irq_clr  input  1  clears irq.
REQ-012 Port: count  output  WIDTH  current count value, registered.
REQ-013 Port: busy  output  1  high while state is RUN.
REQ-014 Port: done  output  1  one-cycle pulse at each terminal count.
REQ-015 Port: irq  output  1  sticky terminal-count flag.
REQ-016 Port: state  output  2  FSM state encoding: IDLE=00, RUN=01, DONE=10.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE; encoding 11 SHALL be unreachable and SHALL return to IDLE on the next clock.
REQ-018 In IDLE or DONE, start=1 (with stop=0) SHALL capture load_val, prescale and periodic into shadow registers, clear count and the prescaler, and enter RUN on the next cycle.
REQ-019 Changes to load_val, prescale or periodic SHALL have no effect while in RUN; only the shadow copies are used.
REQ-020 In RUN, the prescaler SHALL increment every cycle; when it equals shadow prescale, it SHALL reset to 0 and generate a tick. prescale=0 SHALL tick every cycle.
REQ-021 On a tick with count != shadow load_val, count SHALL increment by 1 (unsigned, WIDTH bits).
REQ-022 On a tick with count == shadow load_val (terminal), the block SHALL:
  - set count to 0;
  - drive done=1 for exactly one cycle;
  - set irq=1;
  - stay in RUN if periodic=1, otherwise go to DONE.
REQ-023 The period SHALL be (load_val+1)*(prescale+1) cycles. load_val=0 SHALL terminate on every tick. load_val=all-ones SHALL give 2^WIDTH ticks without overflow.
REQ-024 Latency, with prescale=0 and load_val=L, start sampled at edge N:
  - busy=1 and count=0 after edge N+1;
  - done=1 and count=0 after edge N+L+2.
REQ-025 start while in RUN SHALL be ignored; no restart occurs.
REQ-026 stop while in RUN SHALL move to IDLE on the next cycle, freeze count at its current value, and produce no done pulse and no irq change.
REQ-027 stop SHALL take priority over a simultaneous start and over a simultaneous terminal tick.
REQ-028 In DONE, stop=1 or irq_clr=1 SHALL move to IDLE; count SHALL hold at 0.
REQ-029 irq_clr SHALL clear irq on the next cycle; an irq set from a terminal tick SHALL win over a simultaneous irq_clr.
REQ-030 busy SHALL equal (state==RUN); done SHALL be 0 in every cycle that is not immediately after a terminal tick.

Reset
REQ-031 res=1 at a rising edge SHALL force, on the next cycle:
  - state=IDLE;
  - count, prescaler and shadow registers = 0;
  - done=0, irq=0, busy=0.
REQ-032 res SHALL override all other inputs, including in mid-RUN and mid-prescale.
REQ-033 res SHALL NOT act asynchronously; outputs SHALL change only on a clock edge.

Verification
REQ-034 One-shot: prescale=0, load_val=3, periodic=0, start pulse at edge N -> count 0,1,2,3 after edges N+1..N+4; done=1 with count=0 and state=DONE after N+5; irq=1.
REQ-035 Periodic with prescale: prescale=2, load_val=1, periodic=1 -> done pulses every 6 cycles; busy stays 1; irq stays 1 until irq_clr.
REQ-036 Abort: stop asserted while count=5 (load_val=9) -> state=IDLE and count=5 on the next cycle; no done pulse; irq unchanged.
REQ-037 Simultaneous events:
  - stop together with a terminal tick -> IDLE with no done pulse;
  - irq_clr together with a terminal tick -> irq remains 1.
REQ-038 Reset mid-RUN: res=1 while count=7 -> all outputs 0 and state=IDLE next cycle; a start after res deasserts relaunches normally.
REQ-039 Boundary: load_val=8'hFF, prescale=0 -> done occurs exactly 256 ticks after RUN entry; changing load_val during RUN has no effect.
